// File: rtl/prefix_add_sched_if.sv
// prefix_add_sched_if: bundles the request, response and shared-adder
// signals of prefix_add_sched.
//   req_valid/req_ready/req_a/req_b/req_cin : per-requester request port
//   rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout : tagged result port
//   add_a/add_b/add_sum/add_cout : byte lane to the external 8-bit adder
// slave  : the scheduler side
// master : the environment (requesters, result consumer, adder)
interface prefix_add_sched_if #(
    parameter int NREQ   = 4,
    parameter int NBYTES = 4,
    parameter int IDW    = $clog2(NREQ)
);
    localparam int W = 8 * NBYTES;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [7:0]        add_a;
    logic [7:0]        add_b;
    logic [7:0]        add_sum;
    logic              add_cout;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready, add_sum, add_cout,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready, add_sum, add_cout,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b
    );
endinterface

// File: rtl/prefix_add_sched.sv
// prefix_add_sched: round-robin scheduler sharing one external 8-bit adder
// (no carry-in) among NREQ requesters. Each accepted request is an
// NBYTES-wide A+B+cin, processed LSB byte first, one byte per cycle, with the
// running carry folded into each adder result here.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : prefix_add_sched_if.slave (request, response and adder signals)
module prefix_add_sched #(
    parameter int NREQ   = 4,
    parameter int NBYTES = 4,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prefix_add_sched_if.slave     bus
);
    localparam int W   = 8 * NBYTES;
    localparam int IXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   sum_acc;
    logic           carry;
    logic [IXW-1:0] idx;
    logic [IDW-1:0] last_grant;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_sum_q;
    logic           rsp_cout_q;

    logic [IDW-1:0] grant;
    logic           grant_hit;
    logic [IDW:0]   cand;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           cin_sel;
    logic [7:0]     byte_val;
    logic           c_next;
    logic [W-1:0]   sum_next;

    // Round-robin search starting just after last_grant; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_hit = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last_grant} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!grant_hit && bus.req_valid[cand[IDW-1:0]]) begin
                grant_hit = 1'b1;
                grant     = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                a_sel   = bus.req_a[i*W +: W];
                b_sel   = bus.req_b[i*W +: W];
                cin_sel = bus.req_cin[i];
            end
        end
    end

    // The adder has no carry-in, so the running carry is added afterwards;
    // a carry can only ripple through this second add when add_sum is 8'hFF.
    always_comb begin
        byte_val = bus.add_sum + {7'b0, carry};
        c_next   = bus.add_cout | (carry & (bus.add_sum == 8'hFF));
        sum_next = sum_acc;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (idx == IXW'(k))
                sum_next[8*k +: 8] = byte_val;
        end
    end

    assign bus.req_ready = (state == IDLE && grant_hit) ? (NREQ'(1) << grant) : '0;
    // Operand shifters drain to zero over the NBYTES RUN cycles, so the adder
    // lane is zero outside RUN without extra gating.
    assign bus.add_a     = a_sh[7:0];
    assign bus.add_b     = b_sh[7:0];
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;

    // Bytes collect in sum_acc; the rsp_* registers load only on entry to
    // DONE so they never move while a result is being built.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_acc     <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            last_grant  <= IDW'(NREQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_hit) begin
                        a_sh       <= a_sel;
                        b_sh       <= b_sel;
                        carry      <= cin_sel;
                        idx        <= '0;
                        last_grant <= grant;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 8;
                    b_sh    <= b_sh >> 8;
                    sum_acc <= sum_next;
                    carry   <= c_next;
                    if (idx == IXW'(NBYTES - 1)) begin
                        rsp_sum_q   <= sum_next;
                        rsp_cout_q  <= c_next;
                        rsp_id_q    <= last_grant;
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IXW'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prefix_add_sched.sv
module tb_prefix_add_sched;
    localparam int NREQ   = 4;
    localparam int NBYTES = 4;
    localparam int W      = 32;
    localparam int IDW    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prefix_add_sched_if #(.NREQ(NREQ), .NBYTES(NBYTES), .IDW(IDW)) bus ();

    // External shared adder: 8-bit, no carry-in.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    prefix_add_sched #(.NREQ(NREQ), .NBYTES(NBYTES), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W-1:0] ta  [NREQ];
    logic [W-1:0] tbv [NREQ];
    logic         tc  [NREQ];
    logic         tv  [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = ta[i];
            bus.req_b[i*W +: W] = tbv[i];
            bus.req_cin[i]      = tc[i];
            bus.req_valid[i]    = tv[i];
        end
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]      obs_a [NBYTES];
    logic [7:0]      obs_b [NBYTES];
    logic [7:0]      obs_s [NBYTES];
    logic            obs_c [NBYTES];
    logic [W-1:0]    o_sum;
    logic            o_cout;
    logic [IDW-1:0]  o_id;
    logic [NREQ-1:0] o_grant;
    int              o_lat;
    int              o_pulses;
    bit              o_timeout;

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic window();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            tv[i] = 1'b0; tc[i] = 1'b0; ta[i] = '0; tbv[i] = '0;
        end
        window();
        window();
        rst_n = 1'b1;
        window();
    endtask

    // Drives one request from requester id and records what the DUT shows.
    task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin);
        int k;
        o_timeout = 1'b0;
        o_pulses  = 0;
        o_lat     = 0;
        ta[id] = a; tbv[id] = b; tc[id] = cin; tv[id] = 1'b1;
        #1;
        k = 0;
        while (bus.req_ready[id] !== 1'b1 && k < 50) begin
            window();
            k++;
        end
        if (k >= 50) begin
            o_timeout = 1'b1;
            tv[id] = 1'b0;
            return;
        end
        o_grant  = bus.req_ready;
        o_pulses = 1;
        window();
        tv[id] = 1'b0;
        #1;
        k = 0;
        while (bus.rsp_valid !== 1'b1 && k < 50) begin
            if (k < NBYTES) begin
                obs_a[k] = bus.add_a; obs_b[k] = bus.add_b;
                obs_s[k] = bus.add_sum; obs_c[k] = bus.add_cout;
            end
            if (bus.req_ready[id] === 1'b1) o_pulses++;
            window();
            k++;
        end
        if (k >= 50) o_timeout = 1'b1;
        o_lat  = k + 1;
        o_sum  = bus.rsp_sum;
        o_cout = bus.rsp_cout;
        o_id   = bus.rsp_id;
        window();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            tv[i] = 1'b0; tc[i] = 1'b0; ta[i] = '0; tbv[i] = '0;
        end
        window();
        window();
        checks++;
        if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", bus.req_ready); end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
        checks++;
        if ({bus.rsp_id, bus.rsp_sum, bus.rsp_cout} !== '0) begin
            errors++; $display("FAIL reset_rsp got id %h sum %h cout %b exp all 0", bus.rsp_id, bus.rsp_sum, bus.rsp_cout);
        end
        checks++;
        if ({bus.add_a, bus.add_b} !== 16'h0) begin
            errors++; $display("FAIL reset_add got a %h b %h exp 0", bus.add_a, bus.add_b);
        end
        rst_n = 1'b1;
        window();
        checks++;
        if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL idle_quiet got req_ready %b rsp_valid %b exp 0 0", bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] a, b, sh;
        a = 32'h1234_5678;
        b = 32'h1111_1111;
        run_op(2, a, b, 1'b0);
        checks++;
        if (o_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout got 1 exp 0"); end
        checks++;
        if (o_grant !== 4'b0100 || o_pulses != 1) begin
            errors++; $display("FAIL single_grant got %b pulses %0d exp 0100 pulses 1", o_grant, o_pulses);
        end
        for (int k = 0; k < NBYTES; k++) begin
            sh = a >> (8 * k);
            checks++;
            if (obs_a[k] !== sh[7:0] || obs_b[k] !== 8'h11) begin
                errors++; $display("FAIL single_add_byte%0d got a %h b %h exp a %h b 11", k, obs_a[k], obs_b[k], sh[7:0]);
            end
        end
        checks++;
        if (o_sum !== 32'h2345_6789 || o_cout !== 1'b0 || o_id !== 2'd2) begin
            errors++; $display("FAIL single_rsp got sum %h cout %b id %0d exp 23456789 0 2", o_sum, o_cout, o_id);
        end
        checks++;
        if (o_lat != NBYTES + 1) begin errors++; $display("FAIL single_latency got %0d exp %0d", o_lat, NBYTES + 1); end
        checks++;
        if (bus.rsp_valid !== 1'b0 || {bus.add_a, bus.add_b} !== 16'h0) begin
            errors++; $display("FAIL single_after got rsp_valid %b add %h%h exp 0", bus.rsp_valid, bus.add_a, bus.add_b);
        end
    endtask

    task automatic test_ripple();
        run_op(1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        checks++;
        if (o_timeout !== 1'b0) begin errors++; $display("FAIL ripple_timeout got 1 exp 0"); end
        for (int k = 0; k < NBYTES; k++) begin
            checks++;
            if (obs_s[k] !== 8'hFF || obs_c[k] !== 1'b0) begin
                errors++; $display("FAIL ripple_adder%0d got sum %h cout %b exp ff 0", k, obs_s[k], obs_c[k]);
            end
        end
        checks++;
        if (o_sum !== 32'h0 || o_cout !== 1'b1 || o_id !== 2'd1) begin
            errors++; $display("FAIL ripple_rsp got sum %h cout %b id %0d exp 0 1 1", o_sum, o_cout, o_id);
        end
    endtask

    task automatic test_mixed();
        run_op(0, 32'h80FF_FF80, 32'h8000_0080, 1'b0);
        checks++;
        if (o_timeout !== 1'b0 || o_sum !== 32'h0100_0000 || o_cout !== 1'b1 || o_id !== 2'd0) begin
            errors++; $display("FAIL mixed_rsp got sum %h cout %b id %0d to %b exp 01000000 1 0", o_sum, o_cout, o_id, o_timeout);
        end
    endtask

    task automatic test_round_robin();
        logic [W:0]     q_ref[$];
        int             q_id[$];
        int             order[5];
        int             exp_order[5] = '{0, 1, 2, 3, 0};
        int             ngrant, nrsp, cyc, g, pend;
        logic [W:0]     r;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = $urandom; tbv[i] = $urandom; tc[i] = 1'($urandom_range(0, 1)); tv[i] = 1'b1;
        end
        #1;
        ngrant = 0; nrsp = 0; cyc = 0; pend = -1;
        while (nrsp < 5 && cyc < 200) begin
            if (bus.req_ready !== '0) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i] === 1'b1) g = i;
                checks++;
                if ($countones(bus.req_ready) != 1) begin
                    errors++; $display("FAIL rr_onehot got %b exp one-hot", bus.req_ready);
                end
                if (ngrant < 5) order[ngrant] = g;
                ngrant++;
                q_ref.push_back(ref_add(ta[g], tbv[g], tc[g]));
                q_id.push_back(g);
                pend = g;
            end
            if (bus.rsp_valid === 1'b1) begin
                checks++;
                if (q_ref.size() == 0) begin
                    errors++; $display("FAIL rr_unexpected_rsp got id %0d exp none", bus.rsp_id);
                end else begin
                    r = q_ref.pop_front();
                    g = q_id.pop_front();
                    if ({bus.rsp_cout, bus.rsp_sum} !== r || bus.rsp_id !== IDW'(g)) begin
                        errors++; $display("FAIL rr_rsp%0d got id %0d %b_%h exp id %0d %b_%h", nrsp,
                                           bus.rsp_id, bus.rsp_cout, bus.rsp_sum, g, r[W], r[W-1:0]);
                    end
                end
                nrsp++;
            end
            if (nrsp >= 5) break;
            window();
            if (pend >= 0) begin
                ta[pend] = $urandom; tbv[pend] = $urandom; tc[pend] = 1'($urandom_range(0, 1));
                pend = -1;
                #1;
            end
            cyc++;
        end
        for (int i = 0; i < NREQ; i++) tv[i] = 1'b0;
        checks++;
        if (nrsp < 5) begin errors++; $display("FAIL rr_timeout got %0d responses exp 5", nrsp); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= ngrant || order[i] != exp_order[i]) begin
                errors++; $display("FAIL rr_order%0d got %0d exp %0d", i, (i < ngrant) ? order[i] : -1, exp_order[i]);
            end
        end
        window();
    endtask

    task automatic test_backpressure();
        int k;
        logic [W-1:0] s_sum;
        logic         s_cout;
        logic [IDW-1:0] s_id;
        logic [W:0]   r;
        bit           bad;
        apply_reset();
        bus.rsp_ready = 1'b0;
        ta[1] = $urandom; tbv[1] = $urandom; tc[1] = 1'b1; tv[1] = 1'b1;
        #1;
        k = 0;
        while (bus.req_ready[1] !== 1'b1 && k < 50) begin window(); k++; end
        window();
        tv[1] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (i != 1) begin
                ta[i] = $urandom; tbv[i] = $urandom; tc[i] = 1'($urandom_range(0, 1)); tv[i] = 1'b1;
            end
        end
        #1;
        k = 0;
        while (bus.rsp_valid !== 1'b1 && k < 50) begin window(); k++; end
        r = ref_add(ta[1], tbv[1], tc[1]);
        checks++;
        if (k >= 50 || {bus.rsp_cout, bus.rsp_sum} !== r || bus.rsp_id !== 2'd1) begin
            errors++; $display("FAIL bp_rsp got id %0d %b_%h exp id 1 %b_%h", bus.rsp_id, bus.rsp_cout, bus.rsp_sum, r[W], r[W-1:0]);
        end
        s_sum = bus.rsp_sum; s_cout = bus.rsp_cout; s_id = bus.rsp_id;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            window();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== s_sum || bus.rsp_cout !== s_cout ||
                bus.rsp_id !== s_id || bus.req_ready !== '0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL bp_hold got valid %b sum %h id %0d req_ready %b exp held, req_ready 0",
                               bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.req_ready);
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release_comb got req_ready %b valid %b exp 0 1", bus.req_ready, bus.rsp_valid);
        end
        window();
        checks++;
        if (bus.req_ready !== 4'b0100 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_next_grant got req_ready %b valid %b exp 0100 0", bus.req_ready, bus.rsp_valid);
        end
        r = ref_add(ta[2], tbv[2], tc[2]);
        window();
        for (int i = 0; i < NREQ; i++) tv[i] = 1'b0;
        k = 0;
        while (bus.rsp_valid !== 1'b1 && k < 50) begin window(); k++; end
        checks++;
        if (k >= 50 || {bus.rsp_cout, bus.rsp_sum} !== r || bus.rsp_id !== 2'd2) begin
            errors++; $display("FAIL bp_second got id %0d %b_%h exp id 2 %b_%h", bus.rsp_id, bus.rsp_cout, bus.rsp_sum, r[W], r[W-1:0]);
        end
        window();
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] a1, b1, a0, b0;
        logic [W:0]   r;
        bit           seen;
        int           k;
        apply_reset();
        a1 = $urandom; b1 = $urandom;
        ta[1] = a1; tbv[1] = b1; tc[1] = 1'b1; tv[1] = 1'b1;
        #1;
        k = 0;
        while (bus.req_ready[1] !== 1'b1 && k < 50) begin window(); k++; end
        window();
        tv[1] = 1'b0;
        window();
        window();
        rst_n = 1'b0;
        window();
        checks++;
        if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || {bus.rsp_id, bus.rsp_sum, bus.rsp_cout} !== '0 ||
            {bus.add_a, bus.add_b} !== 16'h0) begin
            errors++; $display("FAIL midrun_reset got rr %b v %b id %0d sum %h c %b add %h%h exp all 0",
                               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.add_a, bus.add_b);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            window();
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrun_no_rsp got rsp_valid 1 exp 0"); end
        ta[2] = $urandom; tbv[2] = $urandom; tc[2] = 1'b0; tv[2] = 1'b1;
        ta[1] = a1; tbv[1] = b1; tc[1] = 1'b1; tv[1] = 1'b1;
        a0 = $urandom; b0 = $urandom;
        run_op(0, a0, b0, 1'b0);
        r = ref_add(a0, b0, 1'b0);
        checks++;
        if (o_timeout || o_grant !== 4'b0001 || {o_cout, o_sum} !== r || o_id !== 2'd0) begin
            errors++; $display("FAIL midrun_prio got grant %b id %0d %b_%h exp 0001 id 0 %b_%h",
                               o_grant, o_id, o_cout, o_sum, r[W], r[W-1:0]);
        end
        run_op(1, a1, b1, 1'b1);
        tv[2] = 1'b0;
        r = ref_add(a1, b1, 1'b1);
        checks++;
        if (o_timeout || o_grant !== 4'b0010 || {o_cout, o_sum} !== r || o_id !== 2'd1) begin
            errors++; $display("FAIL midrun_redo got grant %b id %0d %b_%h exp 0010 id 1 %b_%h",
                               o_grant, o_id, o_cout, o_sum, r[W], r[W-1:0]);
        end
        #1;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         cin;
        logic [W:0]   r;
        int           id;
        for (int n = 0; n < 10; n++) begin
            id  = $urandom_range(0, NREQ - 1);
            cin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = '1; b = '1; end
                2: begin a = $urandom; b = ~a; end
                default: begin a = '0; b = '0; end
            endcase
            run_op(id, a, b, cin);
            r = ref_add(a, b, cin);
            checks++;
            if (o_timeout || {o_cout, o_sum} !== r || o_id !== IDW'(id) || o_lat != NBYTES + 1) begin
                errors++; $display("FAIL random%0d got id %0d %b_%h lat %0d exp id %0d %b_%h lat %0d", n,
                                   o_id, o_cout, o_sum, o_lat, id, r[W], r[W-1:0], NBYTES + 1);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got time limit exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_ripple();
        test_mixed();
        test_round_robin();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
